qspi_read_engine: RTL
=====================

Name: qspi_read_engine

Overview:
- Flash-side initiator for the QSPI data pads.
- Turns a single-word read request into a quad-I/O fast-read transaction (0xEB): serial command, quad address, mode byte, dummy clocks, quad data.
- Drives the pad output/enable lines and collects returning nibbles after the pads' fixed capture latency.
- Sits between the flash bus controller and the four DDR-capable data pads, running at the system clock with SCK at half rate.

Parameters:
- CAPTURE_LAT, 2: i_clk cycles from an SCK rising edge until the pin value appears on i_dat.
- DUMMY_CLKS, 4: SCK cycles with pins released between the mode byte and data. Range 1..15.
- MODE_BYTE, 8'h00: value driven during the two mode SCK cycles.
- CS_HIGH, 4: minimum i_clk cycles CS_N stays high between transactions. Must be > CAPTURE_LAT.

Ports:
- i_clk, input, 1: system clock; all logic on posedge.
- i_reset_n, input, 1: asynchronous active-low reset.
- i_req, input, 1: read request; accepted only when o_busy=0.
- i_addr, input, 24: byte address, latched on accept.
- o_busy, output, 1: transaction or deselect interval in progress.
- o_valid, output, 1: one-cycle pulse; o_data holds the word read.
- o_data, output, 32: read word; first nibble received goes to [31:28]; held until the next o_valid.
- o_cs_n, output, 1: flash chip select.
- o_sck, output, 1: flash clock (registered).
- o_oe, output, 1: pad output enable, common to all four pads.
- o_dat, output, 4: pad output data.
- i_dat, input, 4: pad captured data, delayed CAPTURE_LAT.

Behaviour:
- Reset (async, any time including mid-transaction):
  - o_cs_n=1, o_sck=0, o_oe=0, o_dat=0, o_busy=0, o_valid=0, o_data=0, state=IDLE.
  - Pending capture strobes are cleared.
- Accept: at an edge T where i_req=1 and o_busy=0, latch i_addr and set o_busy=1. i_req while o_busy=1 is ignored; nothing is queued.
- SCK framing:
  - SCK index k occupies cycles T+1+2k (o_sck=0, new o_dat driven) and T+2+2k (o_sck=1).
  - o_cs_n=0 from T+1 through T+56.
- States and SCK indices (DUMMY_CLKS=D; defaults give D=4):
  - CMD, k=0..7: 8'hEB MSB-first on o_dat[0]; o_dat[3:1]=0; o_oe=1.
  - ADDR, k=8..13: address nibbles MSB-first on o_dat[3:0]; o_oe=1.
  - MODE, k=14..15: MODE_BYTE high nibble, then low nibble; o_oe=1.
  - DUMMY, D SCK cycles: o_oe=0, o_dat=0.
  - DATA, 8 SCK cycles: o_oe=0.
  - DESEL: o_cs_n=1, o_sck=0, o_oe=0.
  - Generic transition: each state advances after its last SCK high phase; DESEL→IDLE below.
- Capture:
  - Each DATA-state rising edge at cycle t launches a strobe through a CAPTURE_LAT-deep shift register.
  - At t+CAPTURE_LAT, i_dat is shifted into the assembly register at the LSB, so the first nibble ends in [31:28].
- Completion with defaults (last rising edge at T+56):
  - o_valid=1 at T+57+CAPTURE_LAT (T+59), with o_data updated on the same cycle.
  - DESEL starts at T+57.
  - o_busy=0 at T+57+CS_HIGH (T+61); the earliest next accept is that edge.
- General latency: total SCK cycles N=24+D; o_valid at T+2N+1+CAPTURE_LAT.
- o_sck never glitches and never rises while o_cs_n=1.
- o_oe transitions only while o_sck=0.

Test Plan:
- Reset, then i_req=1 with i_addr=24'h123456 → o_dat[0] serial 1,1,1,0,1,0,1,1 at k=0..7, then nibbles 1,2,3,4,5,6, then 0,0; o_oe falls at cycle T+33.
- Flash model returns bytes DE AD BE EF at pins (applied CAPTURE_LAT-aligned) → o_valid pulse at T+59, o_data=32'hDEADBEEF, o_busy low at T+61.
- i_req held high continuously → accepts at T and T+61 only; CS_N high exactly cycles T+57..T+60; the second transaction is identical.
- i_req pulsed at T+20 during a busy transaction → ignored; no extra SCK edges; only one o_valid.
- i_reset_n asserted at T+40 mid-ADDR/DUMMY → same-cycle o_cs_n=1, o_sck=0, o_oe=0; no o_valid afterwards; a fresh request after release completes normally.
- CAPTURE_LAT=3, DUMMY_CLKS=6 → o_valid at T+2·30+1+3=T+64, data correct; SCK count under CS_N low equals 30.

Source files
------------

// File: rtl/qspi_read_engine.sv
// Quad-I/O fast-read (0xEB) initiator: one 32-bit word per request, SCK at half the core rate, o_valid 2N+1+CAPTURE_LAT cycles after accept.
// No queueing: i_req is accepted only while o_busy=0, which stays set through the CS_N deselect interval.
module qspi_read_engine #(
  parameter int unsigned CAPTURE_LAT = 2,
  parameter int unsigned DUMMY_CLKS  = 4,
  parameter logic [7:0]  MODE_BYTE   = 8'h00,
  parameter int unsigned CS_HIGH     = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req,
  input  logic [23:0] i_addr,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_cs_n,
  output logic        o_sck,
  output logic        o_oe,
  output logic [3:0]  o_dat,
  input  logic [3:0]  i_dat
);
  localparam logic [7:0] CMD_OP = 8'hEB;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, DESEL} state_t;

  state_t      state, state_nxt, follow;
  logic [3:0]  cnt, cnt_nxt, last;
  logic        ph, ph_nxt;
  logic [23:0] addr;
  logic        sck_nxt, cs_n_nxt, oe_nxt;
  logic [3:0]  dat_nxt, nib, addr_nib;
  logic        rise, rise_nxt, accept, drive;

  logic [CAPTURE_LAT-1:0] strb;
  logic [31:0]            shreg;
  logic [2:0]             cap_cnt;

  assign o_busy = (state != IDLE);

  always_comb begin
    case (cnt[2:0])
      3'd0:    addr_nib = addr[23:20];
      3'd1:    addr_nib = addr[19:16];
      3'd2:    addr_nib = addr[15:12];
      3'd3:    addr_nib = addr[11:8];
      3'd4:    addr_nib = addr[7:4];
      3'd5:    addr_nib = addr[3:0];
      default: addr_nib = 4'h0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ph_nxt    = ph;
    sck_nxt   = o_sck;
    cs_n_nxt  = o_cs_n;
    oe_nxt    = o_oe;
    dat_nxt   = o_dat;
    rise_nxt  = 1'b0;
    accept    = 1'b0;
    drive     = 1'b0;
    nib       = 4'h0;
    last      = 4'd0;
    follow    = IDLE;

    case (state)
      CMD:   begin drive = 1'b1; nib = {3'b000, CMD_OP[3'd7 - cnt[2:0]]}; last = 4'd7; follow = ADDR; end
      ADDR:  begin drive = 1'b1; nib = addr_nib; last = 4'd5; follow = MODE; end
      MODE:  begin drive = 1'b1; nib = cnt[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4]; last = 4'd1; follow = DUMMY; end
      DUMMY: begin last = 4'(DUMMY_CLKS - 1); follow = DATA; end
      DATA:  begin last = 4'd7; follow = DESEL; end
      default: ;
    endcase

    case (state)
      IDLE: begin
        sck_nxt  = 1'b0;
        cs_n_nxt = 1'b1;
        oe_nxt   = 1'b0;
        dat_nxt  = 4'h0;
        if (i_req) begin
          accept    = 1'b1;
          state_nxt = CMD;
          cnt_nxt   = 4'd0;
          ph_nxt    = 1'b0;
        end
      end
      DESEL: begin
        sck_nxt  = 1'b0;
        cs_n_nxt = 1'b1;
        oe_nxt   = 1'b0;
        dat_nxt  = 4'h0;
        if (cnt == 4'(CS_HIGH - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        // ph=0: next edge is the SCK low phase (pads change, OE may change); ph=1: SCK rises
        cs_n_nxt = 1'b0;
        if (!ph) begin
          sck_nxt = 1'b0;
          oe_nxt  = drive;
          dat_nxt = nib;
          ph_nxt  = 1'b1;
        end else begin
          sck_nxt  = 1'b1;
          ph_nxt   = 1'b0;
          rise_nxt = (state == DATA);
          if (cnt == last) begin
            cnt_nxt   = 4'd0;
            state_nxt = follow;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      ph     <= 1'b0;
      addr   <= 24'h0;
      o_sck  <= 1'b0;
      o_cs_n <= 1'b1;
      o_oe   <= 1'b0;
      o_dat  <= 4'h0;
      rise   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ph     <= ph_nxt;
      o_sck  <= sck_nxt;
      o_cs_n <= cs_n_nxt;
      o_oe   <= oe_nxt;
      o_dat  <= dat_nxt;
      rise   <= rise_nxt;
      if (accept) addr <= i_addr;
    end
  end

  // rise marks the cycle SCK went high in DATA; i_dat carries that nibble CAPTURE_LAT cycles later
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      strb    <= '0;
      shreg   <= 32'h0;
      cap_cnt <= 3'd0;
      o_data  <= 32'h0;
      o_valid <= 1'b0;
    end else begin
      strb    <= (strb << 1) | CAPTURE_LAT'(rise);
      o_valid <= 1'b0;
      if (strb[CAPTURE_LAT-1]) begin
        shreg   <= {shreg[27:0], i_dat};
        cap_cnt <= cap_cnt + 3'd1;
        if (cap_cnt == 3'd7) begin
          o_data  <= {shreg[27:0], i_dat};
          o_valid <= 1'b1;
        end
      end
    end
  end
endmodule
